// File: rtl/out_bank_arb_pkg.sv
// Shared definitions for the output-bank arbiter: sizes, FSM state
// encoding and a small one-hot helper.
// Related build option: OUT_BANK_ARB_FIXED_PRIO_EN (see rr_pick / top).
package out_bank_arb_pkg;

    localparam int NREQ  = 4;               // requesters: CPU, DMA, debug, timer
    localparam int WIDTH = 8;               // bank data width
    localparam int SELW  = 2;               // bank output-port select width
    localparam int IDXW  = $clog2(NREQ);    // width of a requester index

    // Write-sequencing states; encoding is fixed so it can be probed on a bus.
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SETUP  = 2'b01,
        STROBE = 2'b10,
        HOLD   = 2'b11
    } state_e;

    // Requester index to one-hot grant vector.
    function automatic logic [NREQ-1:0] onehot(input logic [IDXW-1:0] idx);
        logic [NREQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/out_bank_arbiter_rr_pick.sv
// Combinational winner selection for the output-bank arbiter.
// Default: round-robin, searching upward from last+1 with wrap-around.
// With OUT_BANK_ARB_FIXED_PRIO_EN defined: fixed priority, req_i[0]
// highest; the history input does not exist in that build.
module rr_pick
    import out_bank_arb_pkg::*;
(
    input  logic [NREQ-1:0] req_i,
`ifndef OUT_BANK_ARB_FIXED_PRIO_EN
    input  logic [IDXW-1:0] last_i,
`endif
    output logic [IDXW-1:0] winner_o,
    output logic            valid_o
);

`ifdef OUT_BANK_ARB_FIXED_PRIO_EN

    // Scan lowest priority first so the highest-priority hit is written last.
    always_comb begin
        // NOTE: every output gets a default before any branch; without it a
        // path that skips the assignment would infer a latch.
        valid_o  = 1'b0;
        winner_o = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req_i[k]) begin
                valid_o  = 1'b1;
                winner_o = IDXW'(k);
            end
        end
    end

`else

    // Scan from offset NREQ (the previous winner, lowest priority) down to
    // offset 1 (the neighbour after it), so the nearest hit wins.
    always_comb begin
        logic [IDXW-1:0] idx;
        valid_o  = 1'b0;
        winner_o = '0;
        idx      = '0;
        for (int k = NREQ; k >= 1; k--) begin
            idx = last_i + IDXW'(k);    // wraps naturally since NREQ is 2**IDXW
            if (req_i[idx]) begin
                valid_o  = 1'b1;
                winner_o = idx;
            end
        end
    end

`endif

endmodule

// File: rtl/out_bank_arbiter.sv
// Output-bank arbiter: shares one 4-port output register bank among four
// requesters. Each transaction runs SETUP -> STROBE -> HOLD so data and
// select are stable one cycle either side of a single registered strobe;
// the bank clocks its registers on bank_we, so the strobe must be clean.
// Build option OUT_BANK_ARB_FIXED_PRIO_EN selects fixed priority instead
// of round-robin and removes the round-robin pointer.
module out_bank_arbiter
    import out_bank_arb_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,      // asynchronous, active low
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*SELW-1:0]  req_sel,
    input  logic [NREQ*WIDTH-1:0] req_data,
    output logic [NREQ-1:0]       gnt,
    output logic [WIDTH-1:0]      bank_data,
    output logic [SELW-1:0]       bank_sel,
    output logic                  bank_we,
    output logic                  busy
);

    state_e            state_q, state_d;
    logic [NREQ-1:0]   gnt_q,   gnt_d;
    logic [WIDTH-1:0]  data_q,  data_d;
    logic [SELW-1:0]   sel_q,   sel_d;
    logic              we_q,    we_d;
    logic              busy_q,  busy_d;

    logic [IDXW-1:0]   pick_idx;
    logic              pick_valid;
    logic [WIDTH-1:0]  pick_data;
    logic [SELW-1:0]   pick_sel;

`ifndef OUT_BANK_ARB_FIXED_PRIO_EN
    logic [IDXW-1:0]   last_q, last_d;
`endif

    rr_pick u_pick (
        .req_i    (req),
`ifndef OUT_BANK_ARB_FIXED_PRIO_EN
        .last_i   (last_q),
`endif
        .winner_o (pick_idx),
        .valid_o  (pick_valid)
    );

    // Route the winning requester's select and data slices.
    always_comb begin
        pick_data = '0;
        pick_sel  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick_idx == IDXW'(i)) begin
                pick_data = req_data[i*WIDTH +: WIDTH];
                pick_sel  = req_sel[i*SELW +: SELW];
            end
        end
    end

    // Next-state and next-output logic; requests are sampled only in IDLE and HOLD.
    always_comb begin
        state_d = state_q;
        gnt_d   = '0;
        we_d    = 1'b0;
        data_d  = data_q;
        sel_d   = sel_q;
`ifndef OUT_BANK_ARB_FIXED_PRIO_EN
        last_d  = last_q;
`endif
        unique case (state_q)
            IDLE, HOLD: begin
                if (pick_valid) begin
                    state_d = SETUP;
                    gnt_d   = onehot(pick_idx);
                    data_d  = pick_data;
                    sel_d   = pick_sel;
`ifndef OUT_BANK_ARB_FIXED_PRIO_EN
                    last_d  = pick_idx;
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            SETUP: begin
                state_d = STROBE;
                we_d    = 1'b1;
            end
            STROBE: begin
                state_d = HOLD;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and output registers; reset clears everything, including the strobe.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            data_q  <= '0;
            sel_q   <= '0;
            we_q    <= 1'b0;
            busy_q  <= 1'b0;
`ifndef OUT_BANK_ARB_FIXED_PRIO_EN
            last_q  <= IDXW'(NREQ - 1);     // req[0] wins the first pick
`endif
        end else begin
            // NOTE: non-blocking assignments here so every register samples
            // the pre-edge values; blocking would chain them within one edge.
            state_q <= state_d;
            gnt_q   <= gnt_d;
            data_q  <= data_d;
            sel_q   <= sel_d;
            we_q    <= we_d;
            busy_q  <= busy_d;
`ifndef OUT_BANK_ARB_FIXED_PRIO_EN
            last_q  <= last_d;
`endif
        end
    end

    assign gnt       = gnt_q;
    assign bank_data = data_q;
    assign bank_sel  = sel_q;
    assign bank_we   = we_q;
    assign busy      = busy_q;

    // Grant is one-hot and only ever visible in SETUP; strobe only in STROBE.
    a_gnt_onehot : assert property (@(posedge clk) disable iff (!reset)
        $onehot0(gnt_q));
    a_gnt_in_setup : assert property (@(posedge clk) disable iff (!reset)
        (gnt_q != '0) |-> (state_q == SETUP));
    a_we_in_strobe : assert property (@(posedge clk) disable iff (!reset)
        we_q |-> (state_q == STROBE));

endmodule

// File: doc/out_bank_arbiter.md
Name: out_bank_arbiter

Overview:
Shares the 4-port output register bank (8-bit data, 2-bit select, write strobe) between up to four requesters: CPU, DMA, debug and timer.
- Picks one pending request per transaction using round-robin priority.
- Sequences the bank's write strobe as a clean registered pulse, because the bank uses the strobe as its register clock.
- Data and select stay stable for one cycle before the strobe and one cycle after it.

Parameters:
NREQ, 4, number of requesters; only 4 is supported. Ports are packed as 4 slices.
WIDTH, 8, data width.
SELW, 2, output-port select width.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-low reset.
req  in  NREQ  per-requester write request; level, held until granted.
req_sel  in  NREQ*SELW  target output port of each requester; slice i belongs to req[i].
req_data  in  NREQ*WIDTH  write data of each requester; slice i belongs to req[i].
gnt  out  NREQ  one-hot, one-cycle pulse: the request has been captured.
bank_data  out  WIDTH  data to the output bank, registered.
bank_sel  out  SELW  port select to the output bank, registered.
bank_we  out  1  write strobe to the output bank, registered, glitch-free.
busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE.
  - gnt=0, bank_we=0, bank_data=0, bank_sel=0, busy=0.
  - Round-robin pointer last=NREQ-1, so req[0] has top priority on the first pick.
- States: IDLE, SETUP, STROBE, HOLD. All outputs come from registers.
- IDLE:
  - If req!=0, pick the winner w: the first set bit searching from last+1 upward, wrapping at NREQ.
  - On the next edge go to SETUP and register bank_data=req_data[w], bank_sel=req_sel[w], gnt=onehot(w), last=w.
  - If req==0, stay in IDLE; outputs hold their values (bank_data/sel keep the last write).
- SETUP: gnt is high for exactly this one cycle; bank_we=0. Next state is STROBE.
- STROBE: bank_we=1 for exactly one cycle; gnt=0. Next state is HOLD.
- HOLD:
  - bank_we=0; data and select unchanged.
  - If req!=0, pick again (same rule) and go directly to SETUP, skipping IDLE. Otherwise go to IDLE.
- Requester rules:
  - Hold req, req_sel and req_data stable until gnt is seen.
  - Deassert req (or present the next word) on the edge after gnt.
  - Req is sampled only in IDLE and HOLD, so the arbiter never sees a stale req.
- Throughput and latency:
  - Back-to-back: one write per 3 cycles.
  - Request to strobe: 2 cycles from IDLE (req sampled at edge n, bank_we high during cycle n+2).
- Same port targeted by several requesters: writes are serialized in grant order; the last grant's data remains in the port.
- Reset asserted mid-transaction: bank_we drops immediately and the FSM returns to IDLE. The aborted write is not retried; the requester's req is still high, so it will be re-arbitrated after reset.
- req dropped before grant: treated as withdrawn; no write occurs.
- Only one gnt bit is ever high, and never in STROBE or HOLD.

Optional Feature:
OUT_BANK_ARB_FIXED_PRIO_EN
- Defined: fixed priority. req[0] is highest, req[NREQ-1] lowest. The pointer `last` is not implemented, and winner selection ignores history.
- Undefined (default): round-robin as above.

Decomposition:
- Package out_bank_arb_pkg holds:
  - state enum: IDLE=2'b00, SETUP=2'b01, STROBE=2'b10, HOLD=2'b11;
  - NREQ, WIDTH, SELW constants.
- One combinational sub-module, rr_pick: inputs req[NREQ] and last; outputs winner index and a valid flag. The fixed-priority variant lives inside it under the macro.
- The FSM and output registers live in the top module.

Test Plan:
1. Reset:
   - Drive reset=0 with req=4'b1111 → gnt=0, bank_we=0, bank_data=0, bank_sel=0, busy=0.
   - Release reset → first gnt=4'b0001.
2. Single write:
   - req[2]=1, sel=2'b11, data=8'hA5 from IDLE at edge n → gnt=4'b0100 in cycle n+1.
   - Then bank_we=1 in n+2 with bank_sel=3, bank_data=A5; bank_we=0 in n+3; IDLE in n+4.
3. Round-robin, requests held continuously:
   - req=4'b1011 → grant order 0,1,3,0,1,3.
   - Strobes 3 cycles apart; no IDLE cycles between them.
4. Same port:
   - req[0] to sel=1 with 8'h11 and req[1] to sel=1 with 8'h22 → two strobes on port 1, in order 11 then 22.
5. Reset mid-STROBE:
   - Assert reset during bank_we=1 → bank_we falls asynchronously; state is IDLE.
   - After release, the still-pending req is re-granted.
6. With OUT_BANK_ARB_FIXED_PRIO_EN: req=4'b1010 held for 3 grants → gnt=4'b0010 each time, req[3] starved.
